// File: rtl/cmd_phy.sv
// cmd_phy: SD CMD-line PHY; frames and serializes a command with CRC7, then
// optionally deserializes and checks the card's 48-bit response.
module cmd_phy #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        iClock_SD,
  input  logic        iReset,
  input  logic        iLoad_send,
  input  logic [5:0]  iCmd_index,
  input  logic [31:0] iCmd_argument,
  input  logic        iResponse_expected,
  input  logic        iCrc_check_enable,
  input  logic        iTimeout_enable,
  input  logic        iSerial_from_card,
  output logic        oSerial_to_card,
  output logic        oCmd_out_enable,
  output logic        oBusy,
  output logic        oDone,
  output logic [47:0] oResponse,
  output logic        oTimeout_error,
  output logic        oCrc_error,
  output logic        oFrame_error
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEND = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RECV = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  logic [2:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [46:0]          tx_q, tx_d, rx_q, rx_d;
  logic [47:0]          resp_q, resp_d, rx_full;
  logic                 out_q, out_d, en_q, en_d;
  logic                 resp_exp_q, resp_exp_d, crc_en_q, crc_en_d, tmo_en_q, tmo_en_d;
  logic                 tmo_err_q, tmo_err_d, crc_err_q, crc_err_d, frame_err_q, frame_err_d;
  logic [39:0]          tx_head;
  logic [6:0]           tx_crc;
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    end
    return c;
  endfunction
  assign tx_head = {2'b01, iCmd_index, iCmd_argument};
  assign tx_crc  = crc7(tx_head);
  // rx_q already holds the start bit and everything received so far
  assign rx_full = {rx_q, iSerial_from_card};
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    resp_d      = resp_q;
    out_d       = out_q;
    en_d        = en_q;
    resp_exp_d  = resp_exp_q;
    crc_en_d    = crc_en_q;
    tmo_en_d    = tmo_en_q;
    tmo_err_d   = tmo_err_q;
    crc_err_d   = crc_err_q;
    frame_err_d = frame_err_q;
    case (state_q)
      S_IDLE: if (iLoad_send) begin
        state_d     = S_SEND;
        out_d       = tx_head[39];
        en_d        = 1'b1;
        tx_d        = {tx_head[38:0], tx_crc, 1'b1};
        cnt_d       = CNT_WIDTH'(47);
        resp_exp_d  = iResponse_expected;
        crc_en_d    = iCrc_check_enable;
        tmo_en_d    = iTimeout_enable;
        tmo_err_d   = 1'b0;
        crc_err_d   = 1'b0;
        frame_err_d = 1'b0;
      end
      S_SEND: if (cnt_q == '0) begin
        out_d   = 1'b1;
        en_d    = 1'b0;
        cnt_d   = '0;
        state_d = resp_exp_q ? S_WAIT : S_DONE;
      end else begin
        out_d = tx_q[46];
        tx_d  = {tx_q[45:0], 1'b1};
        cnt_d = cnt_q - CNT_WIDTH'(1);
      end
      S_WAIT: if (!iSerial_from_card) begin
        state_d = S_RECV;
        rx_d    = '0;
        cnt_d   = CNT_WIDTH'(46);
      end else if (tmo_en_q && cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
        tmo_err_d = 1'b1;
        state_d   = S_DONE;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
      S_RECV: begin
        rx_d  = rx_full[46:0];
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == '0) begin
          resp_d      = rx_full;
          frame_err_d = rx_full[46] | ~rx_full[0];
          crc_err_d   = crc_en_q & (crc7(rx_full[47:8]) != rx_full[7:1]);
          state_d     = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge iClock_SD) begin
    if (iReset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      resp_q      <= '0;
      out_q       <= 1'b1;
      en_q        <= 1'b0;
      resp_exp_q  <= 1'b0;
      crc_en_q    <= 1'b0;
      tmo_en_q    <= 1'b0;
      tmo_err_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      resp_q      <= resp_d;
      out_q       <= out_d;
      en_q        <= en_d;
      resp_exp_q  <= resp_exp_d;
      crc_en_q    <= crc_en_d;
      tmo_en_q    <= tmo_en_d;
      tmo_err_q   <= tmo_err_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign oSerial_to_card = out_q;
  assign oCmd_out_enable = en_q;
  assign oBusy           = state_q != S_IDLE;
  assign oDone           = state_q == S_DONE;
  assign oResponse       = resp_q;
  assign oTimeout_error  = tmo_err_q;
  assign oCrc_error      = crc_err_q;
  assign oFrame_error    = frame_err_q;
endmodule

// File: tb/tb_cmd_phy.sv
// tb_cmd_phy: randomized and directed checks of cmd_phy against a frame/CRC reference model.
module tb_cmd_phy;
  localparam int T = 64;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [5:0]  idx_i = '0;
  logic [31:0] arg_i = '0;
  logic        re_i = 1'b0, ce_i = 1'b0, te_i = 1'b0;
  logic        ser_in = 1'b1;
  logic        ser_out, en, busy, done, tmo_err, crc_err, frame_err;
  logic [47:0] resp;
  logic [47:0] resp_ref = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  cmd_phy #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(8)) dut (
    .iClock_SD(clk), .iReset(rst), .iLoad_send(load), .iCmd_index(idx_i),
    .iCmd_argument(arg_i), .iResponse_expected(re_i), .iCrc_check_enable(ce_i),
    .iTimeout_enable(te_i), .iSerial_from_card(ser_in), .oSerial_to_card(ser_out),
    .oCmd_out_enable(en), .oBusy(busy), .oDone(done), .oResponse(resp),
    .oTimeout_error(tmo_err), .oCrc_error(crc_err), .oFrame_error(frame_err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  // CRC7 as polynomial long division of message * x^7 by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction
  function automatic logic [47:0] frame_ref(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
  endfunction
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic re,
                         input logic ce, input logic te, input logic [47:0] exp_frame,
                         input logic [47:0] rsp, input int dly, input logic restrobe);
    logic [47:0] got;
    int          en_cnt;
    idx_i = idx; arg_i = arg; re_i = re; ce_i = ce; te_i = te; load = 1'b1;
    tick;
    load = 1'b0;
    idx_i = 6'($urandom); arg_i = $urandom; re_i = ~re; ce_i = ~ce; te_i = ~te;
    check("busy_start", 48'(busy), 48'd1);
    got = '0; en_cnt = 0;
    for (int j = 0; j < 48; j++) begin
      got = {got[46:0], ser_out};
      en_cnt += int'(en);
      tick;
    end
    check("stream", got, exp_frame);
    check("en_cycles", 48'(en_cnt), 48'd48);
    check("release", {46'd0, en, ser_out}, 48'd1);
    if (!re) begin
      check("done_nr", 48'(done), 48'd1);
      check("flags_nr", {45'd0, tmo_err, crc_err, frame_err}, 48'd0);
      check("resp_nr", resp, resp_ref);
    end else if (te && dly >= T) begin
      ser_in = 1'b1;
      repeat (T - 1) tick;
      check("done_early_to", 48'(done), 48'd0);
      tick;
      check("done_to", 48'(done), 48'd1);
      check("flags_to", {45'd0, tmo_err, crc_err, frame_err}, 48'd4);
      check("resp_to", resp, resp_ref);
    end else begin
      for (int d = 0; d < dly; d++) begin
        ser_in = 1'b1;
        if (restrobe && d == 0) begin load = 1'b1; idx_i = 6'd55; re_i = 1'b0; end
        tick;
        load = 1'b0;
        if (restrobe && d == 0) check("restrobe_en", 48'(en), 48'd0);
      end
      for (int j = 47; j >= 0; j--) begin
        ser_in = rsp[j];
        if (j == 0) check("done_early", 48'(done), 48'd0);
        tick;
      end
      ser_in = 1'b1;
      resp_ref = rsp;
      check("done_rx", 48'(done), 48'd1);
      check("resp_rx", resp, rsp);
      check("flags_rx", {45'd0, tmo_err, crc_err, frame_err},
            {45'd0, 1'b0, ce && (crc7_ref(rsp[47:8]) != rsp[7:1]), rsp[46] || !rsp[0]});
    end
    tick;
    check("idle_after", {46'd0, busy, done}, 48'd0);
  endtask
  initial begin
    logic [47:0] r;
    logic [5:0]  ri;
    logic [31:0] ra;
    logic        rre, rce, rte;
    int          dn;
    repeat (2) tick;
    rst = 1'b0;
    check("rst_out", 48'(ser_out), 48'd1);
    check("rst_en", 48'(en), 48'd0);
    check("rst_busy", 48'(busy), 48'd0);
    check("rst_done", 48'(done), 48'd0);
    check("rst_resp", resp, 48'd0);
    check("rst_flags", {45'd0, tmo_err, crc_err, frame_err}, 48'd0);
    run_cmd(6'd0, 32'h0, 1'b0, 1'b1, 1'b1, 48'h400000000095, 48'h0, 0, 1'b0);
    run_cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 1'b1, 48'h48000001AA87, 48'h08000001AA13, 5, 1'b0);
    run_cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 1'b1, 48'h48000001AA87, 48'h08000001AA13 ^ (48'd1 << 20), 5, 1'b0);
    check("crc_flag_set", 48'(crc_err), 48'd1);
    run_cmd(6'd8, 32'h1AA, 1'b1, 1'b0, 1'b1, 48'h48000001AA87, 48'h08000001AA13 ^ (48'd1 << 20), 5, 1'b0);
    run_cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 1'b1, 48'h48000001AA87, 48'h08000001AA12, 3, 1'b0);
    check("frame_flag_set", 48'(frame_err), 48'd1);
    run_cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 1'b1, 48'h48000001AA87, 48'h0, 200, 1'b0);
    run_cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 1'b1, 48'h48000001AA87, 48'h08000001AA13, 5, 1'b1);
    for (int n = 0; n < 40; n++) begin
      ri = 6'($urandom); ra = $urandom;
      rre = 1'($urandom); rce = 1'($urandom); rte = 1'($urandom);
      r = {16'($urandom), $urandom};
      r[47] = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        r[46] = 1'b0; r[7:1] = crc7_ref(r[47:8]); r[0] = 1'b1;
      end
      run_cmd(ri, ra, rre, rce, rte, frame_ref(ri, ra), r, int'($urandom_range(0, 80)), 1'b0);
    end
    idx_i = 6'd2; arg_i = 32'h0; re_i = 1'b1; ce_i = 1'b1; te_i = 1'b0; ser_in = 1'b1; load = 1'b1;
    tick;
    load = 1'b0;
    repeat (499) tick;
    check("no_tmo_busy", {46'd0, busy, done}, 48'd2);
    rst = 1'b1; tick; rst = 1'b0;
    resp_ref = '0;
    check("rst_resp2", resp, 48'd0);
    ra = $urandom;
    r = frame_ref(6'd17, ra);
    idx_i = 6'd17; arg_i = ra; re_i = 1'b1; te_i = 1'b1; load = 1'b1;
    tick;
    load = 1'b0;
    repeat (27) tick;
    check("bit20", 48'(ser_out), 48'(r[20]));
    rst = 1'b1; tick; rst = 1'b0;
    check("rst_mid", {45'd0, en, ser_out, busy}, 48'd2);
    dn = 0;
    repeat (60) begin dn += int'(done); tick; end
    check("rst_no_done", 48'(dn), 48'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cmd_phy.md
# cmd_phy

Physical layer of the SD command path, running on the SD clock. It takes a command index and argument from the command block, builds the 48-bit command frame with CRC7, and shifts it MSB-first onto the CMD line. It then optionally waits for the card's 48-bit response, deserializes it, checks framing and CRC7, and returns the response to the command block with done/error flags.

## Interface
- TIMEOUT_CYCLES, 64: SD clock cycles allowed between end of command and the response start bit.
- CNT_WIDTH, 8: width of the bit/timeout counter; must satisfy 2^CNT_WIDTH > max(48, TIMEOUT_CYCLES).

Ports:
- iClock_SD  in  1  SD clock. Single clock domain; all logic on rising edge.
- iReset  in  1  synchronous, active-high reset.
- iLoad_send  in  1  start strobe; accepted only in IDLE.
- iCmd_index  in  6  command index, sampled on accept.
- iCmd_argument  in  32  command argument, sampled on accept.
- iResponse_expected  in  1  sampled on accept; 0 means no response (e.g. CMD0).
- iCrc_check_enable  in  1  sampled on accept; 0 suppresses the response CRC check (R3).
- iTimeout_enable  in  1  sampled on accept; 0 means wait indefinitely for the start bit.
- iSerial_from_card  in  1  CMD line input.
- oSerial_to_card  out  1  CMD line output; idles at 1.
- oCmd_out_enable  out  1  CMD line drive enable.
- oBusy  out  1  high in every state except IDLE.
- oDone  out  1  one-cycle completion pulse.
- oResponse  out  48  last received response, bit 47 = start bit.
- oTimeout_error  out  1  no start bit within TIMEOUT_CYCLES.
- oCrc_error  out  1  response CRC7 mismatch.
- oFrame_error  out  1  response transmission bit ≠ 0 or end bit ≠ 1.

## Operation
- States: IDLE, SEND, WAIT_RESP, RECEIVE, DONE.
- **Reset values:**
  - State = IDLE.
  - oSerial_to_card = 1.
  - oCmd_out_enable, oBusy, oDone, and all error flags = 0.
  - oResponse = 0.
- **IDLE:**
  - When iLoad_send = 1, latch the frame and the three mode inputs, clear all error flags, and go to SEND.
  - Frame layout:
    - bit 47 = 0 (start bit).
    - bit 46 = 1 (transmission bit).
    - bits 45:40 = index.
    - bits 39:8 = argument.
    - bits 7:1 = CRC7.
    - bit 0 = 1 (end bit).
  - CRC7 uses polynomial x^7+x^3+1 with init 0, computed over bits 47:8 (serially during SEND or combinationally at accept; output timing is identical either way).
- **SEND:**
  - Drive oCmd_out_enable = 1 and output bits 47..0, one per cycle.
  - After bit 0, release the line (enable = 0, out = 1).
  - If the response is expected, go to WAIT_RESP; otherwise go to DONE.
- **WAIT_RESP:**
  - Sample iSerial_from_card every cycle.
  - A sampled 0 is the response start bit (bit 47); go to RECEIVE.
  - If iTimeout_enable = 1 and TIMEOUT_CYCLES samples pass with no 0 seen, set oTimeout_error and go to DONE.
- **RECEIVE:**
  - Shift in the remaining 47 bits MSB-first.
  - After the last bit, load oResponse.
  - oFrame_error = (bit46 ≠ 0) | (bit0 ≠ 1).
  - oCrc_error = iCrc_check_enable & (CRC7(bits 47:8) ≠ bits 7:1).
  - Go to DONE.
- **DONE:**
  - Assert oDone for one cycle and go to IDLE.
- **Held values:**
  - Error flags and oResponse hold until the next accepted iLoad_send.
  - oResponse is not updated on timeout or when no response is expected.
- iLoad_send is ignored in every state except IDLE.
- iReset mid-operation returns to reset values at that edge. The line is released immediately and no oDone is issued.

## Timing
- Reference point: iLoad_send accepted at edge k.
- Bit 47 is driven in cycle k+1, bit 0 in cycle k+48. oCmd_out_enable is high for exactly 48 cycles.
- No response expected: oDone is high in cycle k+49.
- WAIT_RESP occupies cycles from k+49. The first sample is taken in cycle k+49.
- Start bit sampled in cycle s: bits 46..0 are sampled in cycles s+1..s+47, oResponse and flags are valid from cycle s+48, and oDone pulses in cycle s+48.
- Timeout: with no 0 sampled in cycles k+49..k+48+TIMEOUT_CYCLES, oTimeout_error rises and oDone pulses in cycle k+49+TIMEOUT_CYCLES.
- oBusy is high from k+1 through the oDone cycle inclusive. A new iLoad_send is accepted in the cycle after oDone.

## Test plan
- **CMD0 frame:** index 0, arg 0x00000000, no response → serial stream 0x400000000095, enable high 48 cycles, oDone at k+49, no flags.
- **CMD8 round trip:** index 8, arg 0x000001AA → stream 0x48000001AA87. Card answers 0x08000001AA13 starting 5 cycles after release → oResponse = 0x08000001AA13, oCrc_error = 0, oFrame_error = 0, oDone at s+48.
- **CRC failure:** same as the CMD8 round trip but the card flips bit 20 → oCrc_error = 1. With iCrc_check_enable = 0 → oCrc_error = 0.
- **Frame failure:** card response with end bit 0 → oFrame_error = 1.
- **Timeout:** line held at 1 with TIMEOUT_CYCLES = 64 and iTimeout_enable = 1 → oTimeout_error and oDone at k+113, oResponse unchanged. With iTimeout_enable = 0 → still busy at k+500.
- **Reset and re-strobe:** iReset asserted at bit 20 of SEND → next cycle enable = 0, out = 1, oBusy = 0, no oDone. iLoad_send pulsed during WAIT_RESP → ignored, response of the first command delivered unchanged.
